led_axi_burst_slave: RTL and testbench

// AXI4 (full, INCR-only) slave that consumes the LED peripheral's AXI master/VIP traffic: 8 x 32-bit register file plus LED output.

---
 rtl/led_axi_burst_slave_if.sv | 39 +++
 rtl/led_axi_burst_slave.sv | 175 +++++++++++++++++
 tb/tb_led_axi_burst_slave.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/led_axi_burst_slave_if.sv
// AXI4 (INCR-only) bus bundle between the LED peripheral's master/VIP and the burst slave.
interface led_axi_burst_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  araddr, arlen, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output araddr, arlen, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/led_axi_burst_slave.sv
// AXI4 INCR burst slave: 8 x 32-bit register file, reg0 drives the LEDs.
// Optional `LED_BLINK_EN: reg1[0] enables a BLINK_DIV-cycle blink gate on the LEDs.
module led_axi_burst_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_LEDS           = 4,
  parameter int BLINK_DIV          = 25000000
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  led_axi_burst_slave_if.slave    s_axi,
  output logic [NUM_LEDS-1:0]     LED
);
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [8];

  logic [1:0] w_state;
  logic [2:0] w_idx;
  logic [7:0] w_len, w_cnt;
  logic       awready, wready, bvalid;
  logic [1:0] bresp;

  logic [0:0] r_state;
  logic [2:0] r_idx;
  logic [7:0] r_len, r_cnt;
  logic       arready, rvalid, rlast;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  // Byte-offset address bits carry no meaning with an implied 4-byte transfer size.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  assign s_axi.awready = awready;
  assign s_axi.wready  = wready;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;
  assign s_axi.arready = arready;
  assign s_axi.rvalid  = rvalid;
  assign s_axi.rlast   = rlast;
  assign s_axi.rdata   = rdata;
  assign s_axi.rresp   = 2'b00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awready) begin
            if (s_axi.awvalid) begin
              awready <= 1'b0;
              w_idx   <= s_axi.awaddr[4:2];
              w_len   <= s_axi.awlen;
              w_cnt   <= '0;
              wready  <= 1'b1;
              w_state <= W_DATA;
            end
          end else if (s_axi.awvalid) begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid && wready) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
              if (s_axi.wstrb[b]) regs[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            w_idx <= w_idx + 3'd1;
            w_cnt <= w_cnt + 8'd1;
            // Burst ends on WLAST or on the final counted beat; disagreement between them is SLVERR.
            if (s_axi.wlast || (w_cnt == w_len)) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (s_axi.wlast != (w_cnt == w_len)) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready) begin
            if (s_axi.arvalid) begin
              arready <= 1'b0;
              r_idx   <= s_axi.araddr[4:2];
              r_len   <= s_axi.arlen;
              r_cnt   <= '0;
              rvalid  <= 1'b1;
              rdata   <= regs[s_axi.araddr[4:2]];
              rlast   <= (s_axi.arlen == 8'd0);
              r_state <= R_DATA;
            end
          end else if (s_axi.arvalid) begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          // rdata is captured per beat, so it stays frozen while the master stalls.
          if (s_axi.rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_idx + 3'd1;
              r_cnt <= r_cnt + 8'd1;
              rdata <= regs[r_idx + 3'd1];
              rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef LED_BLINK_EN
  logic [31:0] presc;
  logic        phase;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (presc == 32'(BLINK_DIV - 1)) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) LED <= '0;
    else          LED <= regs[0][NUM_LEDS-1:0] & {NUM_LEDS{phase | ~regs[1][0]}};
  end
`else
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) LED <= '0;
    else          LED <= regs[0][NUM_LEDS-1:0];
  end
`endif
endmodule

// File: tb/tb_led_axi_burst_slave.sv
// Scoreboard bench for led_axi_burst_slave: a register model predicts read beats and responses.
module tb_led_axi_burst_slave;
  logic       ACLK = 1'b0;
  logic       ARESETN = 1'b0;
  logic [3:0] LED;

  always #5 ACLK = ~ACLK;

  led_axi_burst_slave_if bus ();

  led_axi_burst_slave #(
    .NUM_LEDS  (4),
    .BLINK_DIV (4)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (bus.slave),
    .LED     (LED)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [8];
  logic [31:0] wbuf [256];
  logic [32:0] rq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Read beats are compared against the model as the DUT hands them over.
  always @(negedge ACLK) begin
    if (ARESETN && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) begin
        chk("r_unexpected", 32'(bus.rdata), 32'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = rq.pop_front();
        chk("rdata", bus.rdata, e[31:0]);
        chk("rlast", 32'(bus.rlast), 32'(e[32]));
      end
    end
  end

  task automatic axi_write(input logic [4:0] addr, input int len, input logic [3:0] strb,
                           input int last_at);
    int n;
    int beats;
    logic [2:0] idx;
    logic [1:0] eresp;
    beats = (last_at < len) ? last_at + 1 : len + 1;
    eresp = (last_at == len) ? 2'b00 : 2'b10;
    @(posedge ACLK); #1;
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awvalid = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (bus.awready) break; end
    if (n == 50) chk("aw_timeout", 0, 1);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0;
    idx = addr[4:2];
    for (int b = 0; b < beats; b++) begin
      bus.wdata = wbuf[b]; bus.wstrb = strb; bus.wlast = (b == last_at); bus.wvalid = 1'b1;
      for (n = 0; n < 50; n++) begin @(negedge ACLK); if (bus.wready) break; end
      if (n == 50) chk("w_timeout", 0, 1);
      @(posedge ACLK); #1;
      for (int k = 0; k < 4; k++) if (strb[k]) mdl[idx][8*k +: 8] = wbuf[b][8*k +: 8];
      idx++;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (bus.bvalid) break; end
    if (n == 50) chk("b_timeout", 0, 1);
    chk("bresp", 32'(bus.bresp), 32'(eresp));
    @(posedge ACLK); #1;
    bus.bready = 1'b0;
    @(negedge ACLK);
    chk("bvalid_drop", 32'(bus.bvalid), 0);
    chk("led", 32'(LED), 32'(mdl[0][3:0]));
  endtask

  task automatic axi_read(input logic [4:0] addr, input int len, input int stall_at);
    int n;
    logic [2:0] idx;
    logic [31:0] sd;
    logic sl;
    idx = addr[4:2];
    for (int b = 0; b <= len; b++) begin
      rq.push_back({(b == len), mdl[idx]});
      idx++;
    end
    @(posedge ACLK); #1;
    bus.araddr = addr; bus.arlen = 8'(len); bus.arvalid = 1'b1;
    for (n = 0; n < 50; n++) begin @(negedge ACLK); if (bus.arready) break; end
    if (n == 50) chk("ar_timeout", 0, 1);
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0;
    @(negedge ACLK);
    chk("rvalid_latency", 32'(bus.rvalid), 1);
    @(posedge ACLK); #1;
    for (int b = 0; b <= len; b++) begin
      if (b == stall_at) begin
        bus.rready = 1'b0;
        @(negedge ACLK);
        sd = bus.rdata; sl = bus.rlast;
        repeat (3) begin
          @(negedge ACLK);
          chk("stall_rvalid", 32'(bus.rvalid), 1);
          chk("stall_rdata", bus.rdata, sd);
          chk("stall_rlast", 32'(bus.rlast), 32'(sl));
        end
        @(posedge ACLK); #1;
      end
      bus.rready = 1'b1;
      for (n = 0; n < 50; n++) begin @(negedge ACLK); if (bus.rvalid) break; end
      if (n == 50) chk("r_timeout", 0, 1);
      @(posedge ACLK); #1;
    end
    bus.rready = 1'b0;
    @(negedge ACLK);
    chk("rvalid_end", 32'(bus.rvalid), 0);
    chk("rq_drained", 32'(rq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;

    #3;
    chk("rst_awready", 32'(bus.awready), 0);
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_bresp", 32'(bus.bresp), 0);
    chk("rst_arready", 32'(bus.arready), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", 32'(bus.rresp), 0);
    chk("rst_rlast", 32'(bus.rlast), 0);
    chk("rst_led", 32'(LED), 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;

    // Full 8-beat burst from register 0.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
    axi_write(5'h00, 7, 4'hF, 7);
    axi_read(5'h00, 7, -1);
    chk("led_burst", 32'(LED), 32'h1);

    // Byte-lane strobe on reg2.
    wbuf[0] = 32'h0000_0003;
    axi_write(5'h08, 0, 4'hF, 0);
    wbuf[0] = 32'hAABB_CCDD;
    axi_write(5'h08, 0, 4'h1, 0);
    chk("model_reg2", mdl[2], 32'h0000_00DD);
    axi_read(5'h08, 0, -1);

    // Wrap from reg6 through reg1.
    wbuf[0] = 32'h0000_000A; wbuf[1] = 32'h0000_000B;
    wbuf[2] = 32'h0000_000C; wbuf[3] = 32'h0000_000D;
    axi_write(5'h18, 3, 4'hF, 3);
    axi_read(5'h18, 3, -1);

    // Early WLAST: only two registers touched, then a normal burst.
    wbuf[0] = 32'h5555_0001; wbuf[1] = 32'h5555_0002;
    axi_write(5'h0C, 3, 4'hF, 1);
    axi_read(5'h00, 7, -1);
    wbuf[0] = 32'h1234_5679; wbuf[1] = 32'h0BAD_F00D;
    axi_write(5'h00, 1, 4'hF, 1);

    // Missing WLAST on the final counted beat.
    wbuf[0] = 32'hCAFE_0001; wbuf[1] = 32'hCAFE_0002;
    axi_write(5'h14, 1, 4'hF, 9);

    // Read stall mid-burst.
    axi_read(5'h00, 7, 3);

    // Long wrapping burst with an unaligned start address.
    for (int i = 0; i < 16; i++) wbuf[i] = $urandom() | 32'h1;
    axi_write(5'h0D, 15, 4'hF, 15);
    axi_read(5'h0D, 19, 5);

    // Reset while a read burst is in flight.
    @(posedge ACLK); #1;
    bus.araddr = 5'h00; bus.arlen = 8'd7; bus.arvalid = 1'b1;
    for (int n = 0; n < 50; n++) begin @(negedge ACLK); if (bus.arready) break; end
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_rvalid", 32'(bus.rvalid), 1);
    chk("pre_rst_led", 32'(LED), 32'(mdl[0][3:0]));
    #1;
    ARESETN = 1'b0;
    #1;
    chk("async_rst_rvalid", 32'(bus.rvalid), 0);
    chk("async_rst_led", 32'(LED), 0);
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    axi_read(5'h00, 7, -1);

    repeat (3) @(posedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
